// File: rtl/restador_div_ctrl.sv
// Restoring shift-subtract unsigned divider, one trial subtraction per clock.
// Latency ANCHO+1 edges to DONE (2 for divide-by-zero); START is ignored while BUSY.
// No input backpressure beyond BUSY; results are registered and held until the next accept.
module restador_div_ctrl #(
  parameter int ANCHO = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [ANCHO-1:0] DIVIDENDO,
  input  logic [ANCHO-1:0] DIVISOR,
  output logic             BUSY,
  output logic             DONE,
  output logic [ANCHO-1:0] COCIENTE,
  output logic [ANCHO-1:0] RESIDUO,
  output logic             DIV0
);

  localparam int                CW   = $clog2(ANCHO + 1);
  localparam logic [CW-1:0]     LAST = CW'(ANCHO - 1);
  localparam logic [ANCHO+1:0]  ONE  = {{(ANCHO+1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t           r_state;
  logic [ANCHO-1:0] r_d;
  logic [ANCHO-1:0] r_q;
  logic [ANCHO:0]   r_r;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_div0;
  logic [ANCHO-1:0] r_coc;
  logic [ANCHO-1:0] r_res;

  logic [ANCHO:0]   w_t;
  logic [ANCHO+1:0] w_diff;
  logic             w_borrow;
  logic [ANCHO:0]   w_r_nxt;
  logic [ANCHO-1:0] w_q_nxt;

  // Trial subtraction through the two's-complement adder path; a set MSB means borrow.
  assign w_t      = {r_r[ANCHO-1:0], r_q[ANCHO-1]};
  assign w_diff   = {1'b0, w_t} + ~{2'b00, r_d} + ONE;
  assign w_borrow = w_diff[ANCHO+1];
  assign w_r_nxt  = w_borrow ? w_t : w_diff[ANCHO:0];
  assign w_q_nxt  = {r_q[ANCHO-2:0], ~w_borrow};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_d     <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_div0  <= 1'b0;
      r_coc   <= '0;
      r_res   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (START) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            if (DIVISOR != '0) begin
              r_d     <= DIVISOR;
              r_q     <= DIVIDENDO;
              r_r     <= '0;
              r_div0  <= 1'b0;
              r_state <= S_RUN;
            end else begin
              r_coc   <= '1;
              r_res   <= DIVIDENDO;
              r_div0  <= 1'b1;
              r_state <= S_FIN;
            end
          end
        end
        S_RUN: begin
          r_r   <= w_r_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_coc   <= w_q_nxt;
            r_res   <= w_r_nxt[ANCHO-1:0];
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          // Divide-by-zero enters FIN with DONE low, so it spends one extra cycle here.
          if (r_done) begin
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_done <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign BUSY     = r_busy;
  assign DONE     = r_done;
  assign COCIENTE = r_coc;
  assign RESIDUO  = r_res;
  assign DIV0     = r_div0;

endmodule

// File: tb/tb_restador_div_ctrl.sv
// Directed and table-driven checks of restador_div_ctrl, plus a held-START sweep against a reference model.
module tb_restador_div_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic [7:0] DIVIDENDO = '0;
  logic [7:0] DIVISOR = '0;
  logic       BUSY;
  logic       DONE;
  logic [7:0] COCIENTE;
  logic [7:0] RESIDUO;
  logic       DIV0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
    int         lat;
  } vec_t;

  vec_t tbl[8];

  restador_div_ctrl #(.ANCHO(8)) dut (
    .CLK(CLK), .RST(RST), .START(START), .DIVIDENDO(DIVIDENDO), .DIVISOR(DIVISOR),
    .BUSY(BUSY), .DONE(DONE), .COCIENTE(COCIENTE), .RESIDUO(RESIDUO), .DIV0(DIV0)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eq,
                       input logic [7:0] er, input logic ez, input int elat, input string nm);
    int lat;
    bit busy_drop;
    busy_drop = 0;
    @(negedge CLK);
    DIVIDENDO = a;
    DIVISOR   = b;
    START     = 1'b1;
    @(negedge CLK);
    START     = 1'b0;
    DIVIDENDO = 8'($urandom);
    DIVISOR   = 8'($urandom);
    lat = 1;
    while (DONE !== 1'b1 && lat < 30) begin
      if (BUSY !== 1'b1) busy_drop = 1;
      @(negedge CLK);
      lat++;
    end
    if (BUSY !== 1'b1) busy_drop = 1;
    chk({nm, " latency"}, lat, elat);
    chk({nm, " busy held"}, busy_drop, 0);
    chk({nm, " cociente"}, COCIENTE, eq);
    chk({nm, " residuo"}, RESIDUO, er);
    chk({nm, " div0"}, DIV0, ez);
    @(negedge CLK);
    chk({nm, " done pulse"}, DONE, 0);
    chk({nm, " busy low"}, BUSY, 0);
  endtask

  initial begin
    tbl[0] = '{a: 8'd200, b: 8'd7,   q: 8'd28,  r: 8'd4,  z: 1'b0, lat: 9};
    tbl[1] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,  z: 1'b0, lat: 9};
    tbl[2] = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,  z: 1'b0, lat: 9};
    tbl[3] = '{a: 8'd0,   b: 8'd3,   q: 8'd0,   r: 8'd0,  z: 1'b0, lat: 9};
    tbl[4] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,  z: 1'b0, lat: 9};
    tbl[5] = '{a: 8'd77,  b: 8'd0,   q: 8'hFF,  r: 8'd77, z: 1'b1, lat: 2};
    tbl[6] = '{a: 8'd10,  b: 8'd3,   q: 8'd3,   r: 8'd1,  z: 1'b0, lat: 9};
    tbl[7] = '{a: 8'd9,   b: 8'd2,   q: 8'd4,   r: 8'd1,  z: 1'b0, lat: 9};

    repeat (3) @(negedge CLK);
    chk("reset busy", BUSY, 0);
    chk("reset done", DONE, 0);
    chk("reset div0", DIV0, 0);
    chk("reset cociente", COCIENTE, 0);
    chk("reset residuo", RESIDUO, 0);
    RST = 1'b0;

    for (int i = 0; i < 8; i++)
      do_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].z, tbl[i].lat, $sformatf("vec%0d", i));

    // A second START mid-run must be dropped, not queued.
    begin
      int ndone;
      logic [7:0] gq, gr;
      ndone = 0; gq = '0; gr = '0;
      @(negedge CLK);
      DIVIDENDO = 8'd100; DIVISOR = 8'd10; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      for (int c = 1; c <= 16; c++) begin
        if (c == 4) begin
          START = 1'b1; DIVIDENDO = 8'd50; DIVISOR = 8'd5;
        end else begin
          START = 1'b0;
        end
        if (DONE === 1'b1) begin
          ndone++; gq = COCIENTE; gr = RESIDUO;
        end
        @(negedge CLK);
      end
      chk("ignore done count", ndone, 1);
      chk("ignore cociente", gq, 10);
      chk("ignore residuo", gr, 0);
    end

    // Asynchronous reset in the middle of an operation.
    begin
      int ndone;
      ndone = 0;
      @(negedge CLK);
      DIVIDENDO = 8'd200; DIVISOR = 8'd7; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      repeat (4) @(negedge CLK);
      RST = 1'b1;
      #1;
      chk("midrst busy", BUSY, 0);
      chk("midrst done", DONE, 0);
      chk("midrst cociente", COCIENTE, 0);
      chk("midrst residuo", RESIDUO, 0);
      chk("midrst div0", DIV0, 0);
      for (int c = 0; c < 12; c++) begin
        @(negedge CLK);
        if (DONE === 1'b1) ndone++;
        if (c == 2) RST = 1'b0;
      end
      chk("midrst no done", ndone, 0);
      do_op(8'd9, 8'd2, 8'd4, 8'd1, 1'b0, 9, "post rst");
    end

    // START held high: each IDLE cycle the bench presents a new pair that the next edge accepts.
    begin
      logic [7:0] qa[$];
      logic [7:0] qb[$];
      logic [7:0] a, b, ea, eb, eq, er;
      int ndone, cyc, npush;
      ndone = 0; cyc = 0; npush = 0;
      @(negedge CLK);
      START = 1'b1;
      while (ndone < 1000 && cyc < 20000) begin
        if (DONE === 1'b1) begin
          if (qa.size() == 0) begin
            chk("sweep spurious done", 1, 0);
          end else begin
            ea = qa.pop_front();
            eb = qb.pop_front();
            eq = (eb == 0) ? 8'hFF : ea / eb;
            er = (eb == 0) ? ea : ea % eb;
            chk($sformatf("sweep q %0d/%0d", ea, eb), COCIENTE, eq);
            chk($sformatf("sweep r %0d/%0d", ea, eb), RESIDUO, er);
            chk($sformatf("sweep z %0d/%0d", ea, eb), DIV0, (eb == 0));
            if (eb != 0)
              chk($sformatf("sweep inv %0d/%0d", ea, eb),
                  ((32'(COCIENTE) * 32'(eb) + 32'(RESIDUO)) == 32'(ea)) && (RESIDUO < eb), 1);
          end
          ndone++;
        end
        if (BUSY === 1'b0) begin
          a = 8'($urandom);
          b = 8'($urandom);
          case (npush % 8)
            0: a = 8'h00;
            1: a = 8'hFF;
            2: b = 8'h00;
            3: b = 8'hFF;
            4: begin a = 8'h00; b = 8'h00; end
            5: begin a = 8'hFF; b = 8'hFF; end
            default: ;
          endcase
          qa.push_back(a);
          qb.push_back(b);
          DIVIDENDO = a;
          DIVISOR   = b;
          npush++;
        end
        @(negedge CLK);
        cyc++;
      end
      START = 1'b0;
      chk("sweep completions", ndone, 1000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
